// File: rtl/mbt_mem_pkg.sv
// Shared memory-path definitions for the pixel engine's BRAM write side.
// Holds the default geometry of the frame buffer (word address width, data
// width, byte-enable width, clear sweep length, clear fill value) and the
// state encoding used by the write arbiter's clear sequencer.
package mbt_mem_pkg;

  localparam int ADDR_W    = 17;
  localparam int DATA_W    = 32;
  localparam int WE_W      = 4;
  localparam int CLR_WORDS = 120000;

  localparam logic [31:0] CLR_VALUE = 32'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selector.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   req[1:0]   : request vector (bit i = requester i)
//   xfer       : strobe, high when the granted request was actually accepted
//   gnt[1:0]   : one-hot grant (all zero when nothing is requested)
// A lone requester is granted at once; with both requesting, the one that did
// not win the last accepted transfer gets the grant. The last-winner pointer
// only moves when a transfer really happens, so a stalled grant stays put.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       xfer,
  output logic [1:0] gnt
);

  // Index of the requester that won the most recent accepted transfer.
  logic last_q, last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Pretend requester 1 went last so requester 0 wins first.
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (xfer) begin
      last_d = gnt[1];
    end
  end

endmodule

// File: rtl/bram_wr_arbiter.sv
// Write-side arbiter for BRAM port A of the frame buffer.
// Two valid/ready write requesters share the port through a round-robin
// arbiter; a clear sequencer can take the port over to sweep CLR_WORDS words
// with CLR_VALUE. All port outputs are registered, so an accepted beat or a
// clear word appears on m_* one cycle after it is issued.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   s0_* / s1_*                : requester valid/ready handshake + addr/data/we
//   clr_start                  : single-cycle clear request (honoured in IDLE)
//   clr_busy                   : high while the sweep is issuing words
//   clr_done                   : one-cycle pulse after the last word is issued
//   m_we, m_addr, m_data       : registered BRAM port A write signals
module bram_wr_arbiter #(
  parameter int                ADDR_W    = mbt_mem_pkg::ADDR_W,
  parameter int                DATA_W    = mbt_mem_pkg::DATA_W,
  parameter int                WE_W      = mbt_mem_pkg::WE_W,
  parameter int                CLR_WORDS = mbt_mem_pkg::CLR_WORDS,
  parameter logic [DATA_W-1:0] CLR_VALUE = mbt_mem_pkg::CLR_VALUE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data,
  input  logic [WE_W-1:0]   s0_we,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
  input  logic [WE_W-1:0]   s1_we,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [WE_W-1:0]   m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data
);

  import mbt_mem_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(CLR_WORDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WE_W-1:0]   m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;

  logic [1:0] gnt;
  logic       accept_en;
  logic       xfer0, xfer1, xfer;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({s1_valid, s0_valid}),
    .xfer  (xfer),
    .gnt   (gnt)
  );

  assign xfer0 = s0_valid & s0_ready;
  assign xfer1 = s1_valid & s1_ready;
  assign xfer  = xfer0 | xfer1;

  // State register plus the registered port A outputs and clear counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      m_we_q   <= '0;
      m_addr_q <= '0;
      m_data_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m_we_q   <= m_we_d;
      m_addr_q <= m_addr_d;
      m_data_q <= m_data_d;
    end
  end

  // Next-state logic. clr_start is only looked at in IDLE, so pulses during
  // a sweep or its done cycle are dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (clr_start) state_d = CLEAR;
      CLEAR:   if (cnt_q == LAST_WORD) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic. Readies are gated by rst_n so nothing is accepted while the
  // block is held in reset, and by clr_start so a clear request wins the cycle.
  always_comb begin
    accept_en = (state_q == IDLE) && !clr_start && rst_n;
    s0_ready  = accept_en & gnt[0];
    s1_ready  = accept_en & gnt[1];
    clr_busy  = (state_q == CLEAR);
    clr_done  = (state_q == DONE);
  end

  // Port A datapath: a clear word, an accepted beat, or an idle cycle that
  // drops the write enable while leaving address and data where they were.
  always_comb begin
    m_we_d   = '0;
    m_addr_d = m_addr_q;
    m_data_d = m_data_q;
    cnt_d    = cnt_q;
    if (state_q == CLEAR) begin
      m_we_d   = '1;
      m_addr_d = cnt_q;
      m_data_d = CLR_VALUE;
      cnt_d    = cnt_q + 1'b1;
    end else if (xfer0) begin
      m_we_d   = s0_we;
      m_addr_d = s0_addr;
      m_data_d = s0_data;
    end else if (xfer1) begin
      m_we_d   = s1_we;
      m_addr_d = s1_addr;
      m_data_d = s1_data;
    end
    if ((state_q == IDLE) && clr_start) begin
      cnt_d = '0;
    end
  end

  assign m_we   = m_we_q;
  assign m_addr = m_addr_q;
  assign m_data = m_data_q;

endmodule

// File: doc/bram_wr_arbiter.md
BRAM_WR_ARBITER -- requirements
Module: bram_wr_arbiter

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- ADDR_W, 17, word address width.
- DATA_W, 32, write data width (4 packed 8-bit pixels).
- WE_W, 4, byte-enable width.
- CLR_WORDS, 120000, number of words swept by clear (800x600/4).
- CLR_VALUE, 32'h0, clear fill word.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  engine-domain clock.
- rst_n  in  1  asynchronous active-low reset.
- s0_valid  in  1  requester 0 has a write beat.
- s0_ready  out  1  requester 0 beat accepted this cycle.
- s0_addr  in  ADDR_W  requester 0 word address.
- s0_data  in  DATA_W  requester 0 write data.
- s0_we  in  WE_W  requester 0 byte enables.
- s1_valid, s1_ready, s1_addr, s1_data, s1_we  same directions and widths, requester 1.
- clr_start  in  1  single-cycle clear request.
- clr_busy  out  1  clear sweep in progress.
- clr_done  out  1  one-cycle pulse at clear completion.
- m_we  out  WE_W  BRAM port A byte enables.
- m_addr  out  ADDR_W  BRAM port A address.
- m_data  out  DATA_W  BRAM port A write data.

Function
REQ-004 SHALL transfer a beat on sX when sX_valid and sX_ready are both high in the same cycle.
REQ-005 SHALL derive sX_ready combinationally from the current grant and state; a requester holds its payload stable while valid until ready.
REQ-006 SHALL register m_we/m_addr/m_data; an accepted beat appears on m_* exactly 1 cycle after transfer.
REQ-007 SHALL drive m_we=0 in any cycle following a cycle with no transfer and no clear write; m_addr/m_data SHALL hold their previous values.
REQ-008 SHALL use a two-way round-robin arbiter: a single valid requester is granted immediately; with both valid, the requester not granted last wins.
REQ-009 SHALL update the last-grant pointer only on an actual transfer.
REQ-010 SHALL assert at most one sX_ready per cycle.
REQ-011 SHALL pass beats with sX_we=0 through as m_we=0 without altering address/data forwarding.
REQ-012 SHALL implement FSM states IDLE, CLEAR, DONE.
- IDLE->CLEAR on clr_start.
- CLEAR->DONE after word CLR_WORDS-1 is issued.
- DONE->IDLE unconditionally after 1 cycle.
REQ-013 SHALL, in CLEAR, hold both sX_ready low and issue one write per cycle: m_we=all-ones, m_data=CLR_VALUE, m_addr=0,1,...,CLR_WORDS-1 in order.
REQ-014 SHALL assert clr_busy exactly while in CLEAR, and clr_done for exactly the DONE cycle.
REQ-015 SHALL ignore clr_start while in CLEAR or DONE.
REQ-016 SHALL give clear priority when clr_start coincides with sX_valid in IDLE: no beat is accepted that cycle.
REQ-017 SHALL resume round-robin in IDLE after DONE with the pointer unchanged by the clear.
REQ-018 SHALL forward addresses unchanged, with no range check.

Reset
REQ-019 SHALL, on rst_n low, asynchronously set state=IDLE, clear counter=0, last-grant=requester 1 (so requester 0 wins first), m_we=0, m_addr=0, m_data=0, clr_busy=0, clr_done=0.
REQ-020 SHALL abort a clear in progress on reset, with no clr_done pulse and no further clear writes after release.
REQ-021 SHALL hold sX_ready low while rst_n is low.

Structure
REQ-022 SHALL place ADDR_W, DATA_W, WE_W, CLR_WORDS and the IDLE/CLEAR/DONE state encoding in shared package mbt_mem_pkg.
REQ-023 SHALL implement grant selection in one sub-module rr_arb2 (inputs req[1:0] and the transfer strobe; output one-hot grant), instantiated once.

Verification
REQ-024 SHALL have the bench cover these scenarios:
- Only s0_valid, addr 0x00010, data 0xAABBCCDD, we 0xF -> s0_ready same cycle; m_* shows that beat the next cycle; s1_ready stays low.
- s0 and s1 both valid for 4 cycles after reset -> grants s0,s1,s0,s1; m_addr sequence matches the requesters' addresses 1 cycle later.
- clr_start with CLR_WORDS overridden to 8 -> clr_busy for 8 cycles; m_addr 0..7 with m_we=0xF and m_data=0; clr_done one cycle; then IDLE.
- clr_start coincident with s0_valid -> no s0_ready that cycle; s0 accepted on the first IDLE cycle after clr_done.
- rst_n low at clear word 3 -> m_we=0 immediately; no clr_done; after release, s1_valid alone is granted in 1 cycle.
- s1_valid with s1_we=0 -> s1_ready high; next-cycle m_we=0.
